// File: rtl/timer_pkg.sv
// Shared definitions for the timer engine.
//   state_e : FSM state encoding for timer_ctrl (IDLE / LOAD / RUN)
//   STATE_W : width of the state register
package timer_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2
  } state_e;

endpackage

// File: rtl/counter.sv
// Generic loadable up/down counter.
//   clk       : clock, rising edge
//   load      : load load_data into the count (highest priority)
//   load_data : value to load
//   en        : counting enable
//   in        : count event; the count steps once per cycle with en && in
//   count     : current count value
//   carry     : borrow (DECREMENT, stepping from 0) or carry (INCREMENT, stepping from all-ones)
// There is no reset port; the owner initialises the count by asserting load.
module counter #(
  parameter int    DW   = 32,
  parameter string TYPE = "DECREMENT"
) (
  input  logic          clk,
  input  logic          load,
  input  logic [DW-1:0] load_data,
  input  logic          en,
  input  logic          in,
  output logic [DW-1:0] count,
  output logic          carry
);

  localparam bit DEC = (TYPE == "DECREMENT");

  logic [DW-1:0] count_q;
  logic [DW-1:0] count_d;
  logic          step;

  assign step = en && in;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_data;
    end else if (step) begin
      count_d = DEC ? (count_q - 1'b1) : (count_q + 1'b1);
    end
  end

  always_ff @(posedge clk) begin
    count_q <= count_d;
  end

  assign count = count_q;
  assign carry = step && !load && (DEC ? (count_q == '0) : (count_q == '1));

endmodule

// File: rtl/timer_ctrl.sv
// Programmable timer engine built around a down-counting counter.
//   clk, reset    : clock and synchronous active-high reset
//   cfg_period    : period in ticks, captured in LOAD
//   cfg_prescale  : tick divisor minus one, captured in LOAD
//   cfg_periodic  : 1 = reload on expiry, 0 = one-shot (sampled on the expiry cycle)
//   start / stop  : single-cycle control requests; stop has priority
//   irq_clear     : clears irq and overrun
//   busy          : timer in LOAD or RUN
//   expired       : one-cycle pulse when the count reaches zero in RUN
//   irq / overrun : sticky status flags
//   count         : current counter value
//
// state | meaning
// IDLE  | waiting for start with a non-zero period
// LOAD  | counter loaded with the period, prescaler restarted
// RUN   | counting down one step per prescaler tick
module timer_ctrl
  import timer_pkg::*;
#(
  parameter int DW = 32,
  parameter int PW = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [DW-1:0] cfg_period,
  input  logic [PW-1:0] cfg_prescale,
  input  logic          cfg_periodic,
  input  logic          start,
  input  logic          stop,
  input  logic          irq_clear,
  output logic          busy,
  output logic          expired,
  output logic          irq,
  output logic          overrun,
  output logic [DW-1:0] count
);

  state_e        state_q;
  logic [PW-1:0] prescale_q;
  logic [PW-1:0] prescaler_q;
  logic          irq_q;
  logic          overrun_q;

  logic          in_run;
  logic          zero;
  logic          tick;
  logic          cnt_load;
  logic [DW-1:0] cnt_data;
  logic          cnt_en;
  logic          carry_unused;

  assign in_run = (state_q == RUN);
  assign zero   = (count == '0);
  assign tick   = (prescaler_q == prescale_q);

  // Reset doubles as a load of zero so the counter needs no reset of its own.
  assign cnt_load = reset || (state_q == LOAD);
  assign cnt_data = reset ? '0 : cfg_period;
  // Counting is suppressed on the zero cycle (never wraps below 0) and on stop (count holds).
  assign cnt_en   = in_run && !zero && !stop;

  counter #(
    .DW  (DW),
    .TYPE("DECREMENT")
  ) u_counter (
    .clk      (clk),
    .load     (cnt_load),
    .load_data(cnt_data),
    .en       (cnt_en),
    .in       (tick),
    .count    (count),
    .carry    (carry_unused)
  );

  // A stop on the zero cycle aborts the expiry.
  assign expired = in_run && zero && !stop;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      prescale_q  <= '0;
      prescaler_q <= '0;
      irq_q       <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start && !stop && (cfg_period != '0)) begin
            state_q <= LOAD;
          end
        end
        LOAD: begin
          prescale_q  <= cfg_prescale;
          prescaler_q <= '0;
          state_q     <= stop ? IDLE : RUN;
        end
        RUN: begin
          if (stop) begin
            state_q     <= IDLE;
            prescaler_q <= '0;
          end else if (zero) begin
            state_q <= cfg_periodic ? LOAD : IDLE;
          end else begin
            prescaler_q <= tick ? '0 : (prescaler_q + 1'b1);
          end
        end
        default: state_q <= IDLE;
      endcase

      // A clear coinciding with an expiry leaves irq set but overrun clear.
      if (irq_clear) begin
        irq_q     <= expired;
        overrun_q <= 1'b0;
      end else if (expired) begin
        irq_q     <= 1'b1;
        overrun_q <= overrun_q | irq_q;
      end
    end
  end

  assign busy    = (state_q == LOAD) || (state_q == RUN);
  assign irq     = irq_q;
  assign overrun = overrun_q;

endmodule

// File: tb/tb_timer_ctrl.sv
module tb_timer_ctrl;

  localparam int DW = 32;
  localparam int PW = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic [DW-1:0] cfg_period;
  logic [PW-1:0] cfg_prescale;
  logic          cfg_periodic;
  logic          start;
  logic          stop;
  logic          irq_clear;
  logic          busy;
  logic          expired;
  logic          irq;
  logic          overrun;
  logic [DW-1:0] count;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  timer_ctrl #(.DW(DW), .PW(PW)) dut (
    .clk         (clk),
    .reset       (reset),
    .cfg_period  (cfg_period),
    .cfg_prescale(cfg_prescale),
    .cfg_periodic(cfg_periodic),
    .start       (start),
    .stop        (stop),
    .irq_clear   (irq_clear),
    .busy        (busy),
    .expired     (expired),
    .irq         (irq),
    .overrun     (overrun),
    .count       (count)
  );

  function automatic void cmp(string nm, longint act, longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", nm, cyc, act, exp);
    end
  endfunction

  // Behavioural model: phase 0=idle, 1=loading, 2=running. While running the
  // count is derived arithmetically from cycles spent running: one step per S+1 cycles.
  int     m_phase = 0;
  longint m_hold  = 0;
  longint m_p     = 0;
  longint m_s     = 0;
  longint m_k     = 0;
  bit     m_irq   = 0;
  bit     m_ovr   = 0;
  bit     m_valid = 0;

  function automatic longint m_count();
    if (m_phase == 2) return m_p - (m_k / (m_s + 1));
    return m_hold;
  endfunction

  function automatic bit m_expired();
    return (m_phase == 2) && (m_count() == 0) && !stop;
  endfunction

  always @(posedge clk) begin : model
    bit     e;
    longint cur;
    e   = m_expired();
    cur = m_count();
    if (reset) begin
      m_phase = 0;
      m_hold  = 0;
      m_k     = 0;
      m_irq   = 0;
      m_ovr   = 0;
      m_valid = 1;
    end else begin
      if (m_phase == 0) begin
        if (start && !stop && cfg_period != 0) m_phase = 1;
      end else if (m_phase == 1) begin
        m_p     = cfg_period;
        m_s     = cfg_prescale;
        m_hold  = cfg_period;
        m_k     = 0;
        m_phase = stop ? 0 : 2;
      end else begin
        if (stop) begin
          m_hold  = cur;
          m_phase = 0;
        end else if (cur == 0) begin
          m_hold  = 0;
          m_phase = cfg_periodic ? 1 : 0;
        end else begin
          m_k++;
        end
      end
      if (irq_clear) begin
        m_irq = e;
        m_ovr = 0;
      end else if (e) begin
        m_ovr = m_ovr | m_irq;
        m_irq = 1;
      end
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      cmp("busy",    busy,    longint'(m_phase != 0));
      cmp("expired", expired, longint'(m_expired()));
      cmp("irq",     irq,     longint'(m_irq));
      cmp("overrun", overrun, longint'(m_ovr));
      cmp("count",   count,   m_count());
    end
  end

  task automatic tick1();
    @(posedge clk);
    #1;
    start     = 1'b0;
    stop      = 1'b0;
    irq_clear = 1'b0;
    reset     = 1'b0;
  endtask

  task automatic adv(int n);
    repeat (n) tick1();
  endtask

  task automatic set_cfg(int p, int s, bit per);
    cfg_period   = DW'(p);
    cfg_prescale = PW'(s);
    cfg_periodic = per;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; stop = 1'b0; irq_clear = 1'b0;
    set_cfg(0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    cmp("rst_count", count, 0);
    cmp("rst_busy", busy, 0);
    cmp("rst_irq", irq, 0);
    adv(3);

    // One-shot P=3 S=0: expiry at cycle 5.
    set_cfg(3, 0, 0); start = 1'b1;
    adv(4); @(negedge clk);
    cmp("t1_count_c4", count, 1);
    cmp("t1_exp_c4", expired, 0);
    adv(1); @(negedge clk);
    cmp("t1_exp_c5", expired, 1);
    adv(1); @(negedge clk);
    cmp("t1_irq_c6", irq, 1);
    cmp("t1_busy_c6", busy, 0);
    irq_clear = 1'b1;
    adv(1); @(negedge clk);
    cmp("t1_irq_cleared", irq, 0);
    adv(2);

    // Periodic P=2 S=3: expiries at 10, 20, 30; overrun on the second.
    set_cfg(2, 3, 1); start = 1'b1;
    adv(10); @(negedge clk);
    cmp("t2_exp_c10", expired, 1);
    adv(10); @(negedge clk);
    cmp("t2_exp_c20", expired, 1);
    adv(1); @(negedge clk);
    cmp("t2_ovr_c21", overrun, 1);
    adv(9); @(negedge clk);
    cmp("t2_exp_c30", expired, 1);
    adv(1); stop = 1'b1;
    adv(1); @(negedge clk);
    cmp("t2_busy_after_stop", busy, 0);
    irq_clear = 1'b1;
    adv(1); @(negedge clk);
    cmp("t2_ovr_cleared", overrun, 0);
    adv(2);

    // Stop mid-run: count holds 6.
    set_cfg(10, 0, 0); start = 1'b1;
    adv(6); stop = 1'b1;
    @(negedge clk);
    cmp("t3_count_c6", count, 6);
    adv(1); @(negedge clk);
    cmp("t3_busy_c7", busy, 0);
    cmp("t3_count_c7", count, 6);
    adv(3); @(negedge clk);
    cmp("t3_count_held", count, 6);
    cmp("t3_no_irq", irq, 0);

    // Zero period ignored; start while running ignored.
    set_cfg(0, 0, 0); start = 1'b1;
    adv(1); @(negedge clk);
    cmp("t4_p0_busy", busy, 0);
    set_cfg(4, 1, 0); start = 1'b1;
    adv(3); start = 1'b1;
    adv(7); @(negedge clk);
    cmp("t4_exp_c10", expired, 1);
    adv(1); irq_clear = 1'b1;
    adv(2);

    // Expiry with simultaneous clear, then stop on the zero cycle.
    set_cfg(2, 0, 1); start = 1'b1;
    adv(4); @(negedge clk);
    cmp("t5_exp_c4", expired, 1);
    adv(4); irq_clear = 1'b1;
    @(negedge clk);
    cmp("t5_exp_c8", expired, 1);
    adv(1); @(negedge clk);
    cmp("t5_irq_c9", irq, 1);
    cmp("t5_ovr_c9", overrun, 0);
    adv(3); stop = 1'b1;
    @(negedge clk);
    cmp("t5_stop_zero_exp", expired, 0);
    adv(1); @(negedge clk);
    cmp("t5_busy_c13", busy, 0);

    // Reset mid-run, then a fresh one-shot.
    set_cfg(5, 0, 0); start = 1'b1;
    adv(4); reset = 1'b1;
    adv(1); @(negedge clk);
    cmp("t6_count_rst", count, 0);
    cmp("t6_busy_rst", busy, 0);
    cmp("t6_irq_rst", irq, 0);
    set_cfg(3, 0, 0); start = 1'b1;
    adv(5); @(negedge clk);
    cmp("t6_exp_c5", expired, 1);
    adv(1); @(negedge clk);
    cmp("t6_irq_c6", irq, 1);
    cmp("t6_busy_c6", busy, 0);
    adv(2);

    // Randomised traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      tick1();
      if ($urandom_range(0, 99) < 10) start = 1'b1;
      if ($urandom_range(0, 99) < 3)  stop = 1'b1;
      if ($urandom_range(0, 99) < 4)  irq_clear = 1'b1;
      if ($urandom_range(0, 399) == 0) reset = 1'b1;
      if ($urandom_range(0, 99) < 4) begin
        set_cfg(int'($urandom_range(0, 6)), int'($urandom_range(0, 3)),
                bit'($urandom_range(0, 1)));
      end
    end
    adv(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
